uart_rx_fsm: RTL

UART_RX_FSM -- requirements
Module: uart_rx_fsm

---
 rtl/uart_rx_fsm.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampling UART receiver for 8 data bits, one stop bit and an
// optional even-parity bit (8N1 or 8E1).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit period (even, >= 4)
//   PARITY_EN     1 = one even-parity bit between data and stop, 0 = none
//
// Ports
//   clk            single clock, all logic on its rising edge
//   reset          synchronous, active-high reset
//   rx             asynchronous serial line, idles high
//   rx_clear       consumer acknowledges the held byte
//   rx_data        last accepted byte
//   rx_valid       rx_data holds an unconsumed byte
//   busy           a frame is in progress
//   framing_error  one-cycle pulse: stop bit sampled low
//   parity_error   one-cycle pulse: parity mismatch with a good stop bit
//   overrun_error  one-cycle pulse: good byte completed while one was still held
module uart_rx_fsm #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_clear,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       framing_error,
    output logic       parity_error,
    output logic       overrun_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // Last count of the half-bit wait (start-bit centre) and of a full bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Odd population count of a byte; with the parity bit folded in, a
    // nonzero result means the even-parity check failed.
    function automatic logic parity_odd(input logic [7:0] data);
        return ^data;
    endfunction

    state_t           state_r;
    logic             sync1_r;
    logic             rxs_r;
    logic             rxs_prev_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             parity_bad_r;
    logic             stop_ok_r;
    logic             done_r;

    // Two-flop synchronizer plus a delayed copy used for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= 1'b1;
            rxs_r      <= 1'b1;
            rxs_prev_r <= 1'b1;
        end else begin
            sync1_r    <= rx;
            rxs_r      <= sync1_r;
            rxs_prev_r <= rxs_r;
        end
    end

    // Frame FSM, baud/bit counters, shift register and registered outputs.
    // The stop sample raises done_r; the following cycle commits the frame, so
    // rx_clear is evaluated in that commit cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            baud_cnt_r    <= '0;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            parity_bad_r  <= 1'b0;
            stop_ok_r     <= 1'b0;
            done_r        <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            busy          <= 1'b0;
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
            done_r        <= 1'b0;

            // Commit of a completed frame, or a standalone acknowledge.
            if (done_r) begin
                if (!stop_ok_r) begin
                    framing_error <= 1'b1;
                    if (rx_clear) begin
                        rx_valid <= 1'b0;
                    end
                end else if (PARITY_EN && parity_bad_r) begin
                    parity_error <= 1'b1;
                    if (rx_clear) begin
                        rx_valid <= 1'b0;
                    end
                end else if (rx_valid && !rx_clear) begin
                    overrun_error <= 1'b1;
                end else begin
                    rx_data  <= shift_r;
                    rx_valid <= 1'b1;
                end
            end else if (rx_clear) begin
                rx_valid <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= '0;
                    // Only a 1->0 transition starts a frame; a stuck-low line does not.
                    if (rxs_prev_r && !rxs_r) begin
                        state_r      <= ST_START;
                        busy         <= 1'b1;
                        parity_bad_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_cnt_r == HALF_LAST) begin
                        baud_cnt_r <= '0;
                        if (!rxs_r) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            // Start bit gone by its centre: a glitch, drop silently.
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_r == FULL_LAST) begin
                        baud_cnt_r <= '0;
                        shift_r    <= {rxs_r, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_cnt_r == FULL_LAST) begin
                        baud_cnt_r   <= '0;
                        parity_bad_r <= parity_odd(shift_r) ^ rxs_r;
                        state_r      <= ST_STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt_r == FULL_LAST) begin
                        baud_cnt_r <= '0;
                        stop_ok_r  <= rxs_r;
                        done_r     <= 1'b1;
                        state_r    <= ST_IDLE;
                        busy       <= 1'b0;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
